// File: rtl/morph_filter_engine.sv
`default_nettype none
// ============================================================================
// Module      : morph_filter_engine
// Description : Streams a binary image out of the source ROM in raster order,
//               applies a 3x3 binary dilation (OR) or erosion (AND) and writes
//               the filtered image to the frame RAM. Raises dilation_done or
//               erosion_done when the pass completes.
// Ports       : clk, rst_n            - clock, async active-low reset
//               dilation_en/erosion_en - level pass requests
//               rom_rd/rom_addr/rom_data - source ROM read (1-cycle latency)
//               ram_we/ram_addr/ram_data - frame RAM write
//               busy                    - pass in progress (RUN/FLUSH)
//               dilation_done/erosion_done - level completion flags
// Revision    : 1.0 - initial release
// ============================================================================
module morph_filter_engine #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dilation_en,
    input  logic              erosion_en,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_data,
    output logic              busy,
    output logic              dilation_done,
    output logic              erosion_done
);

    localparam int                 WIN       = 2 * IMG_W + 3;
    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] CEN_START = ADDR_W'(IMG_W + 1);
    localparam logic [ADDR_W-1:0] LAST_X    = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] LAST_Y    = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_RUN   = 4'b0010,
        S_FLUSH = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_mode;        // 0 = dilation, 1 = erosion
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_d;        // rom_data is valid this cycle
    logic              r_cen;         // window center holds a real pixel
    logic [ADDR_W-1:0] r_q;
    logic [ADDR_W-1:0] r_cx;
    logic [ADDR_W-1:0] r_cy;
    logic [WIN-2:0]    r_win;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_wdata;

    logic              w_mode_en;
    logic              w_start;
    logic              w_active;
    logic              w_abort;
    logic              w_in;
    logic [WIN-1:0]    w_win;
    logic [8:0]        w_nb;
    logic              w_out;
    logic              w_wr;

    assign w_mode_en = r_mode ? erosion_en : dilation_en;
    assign w_start   = (r_state == S_IDLE) && (dilation_en ^ erosion_en);
    assign w_active  = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign w_abort   = w_active && !w_mode_en;

    // The incoming pixel is the window's newest tap, so the full 2*IMG_W+3
    // window is this input stage plus the registered history. This lets the
    // center of pixel q line up with the read of pixel q+IMG_W+1 and keeps
    // the write at C0+IMG_W+3+q. During FLUSH the padding value is fed in;
    // its content never matters because border masking replaces those taps.
    assign w_in  = r_rd_d ? rom_data : r_mode;
    assign w_win = {r_win, w_in};

    // Tap k positions older than the newest holds pixel (q+IMG_W+1)-k.
    always_comb begin
        w_nb[0] = w_win[IMG_W + 1];
        w_nb[1] = (r_cx != '0)                       ? w_win[IMG_W + 2]     : r_mode;
        w_nb[2] = (r_cx != LAST_X)                   ? w_win[IMG_W]         : r_mode;
        w_nb[3] = (r_cy != '0)                       ? w_win[2*IMG_W + 1]   : r_mode;
        w_nb[4] = (r_cy != '0 && r_cx != '0)         ? w_win[2*IMG_W + 2]   : r_mode;
        w_nb[5] = (r_cy != '0 && r_cx != LAST_X)     ? w_win[2*IMG_W]       : r_mode;
        w_nb[6] = (r_cy != LAST_Y)                   ? w_win[1]             : r_mode;
        w_nb[7] = (r_cy != LAST_Y && r_cx != '0)     ? w_win[2]             : r_mode;
        w_nb[8] = (r_cy != LAST_Y && r_cx != LAST_X) ? w_win[0]             : r_mode;
        w_out   = r_mode ? (&w_nb) : (|w_nb);
    end

    assign w_wr = r_cen && w_active && !w_abort;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and control outputs
    always_comb begin
        w_state_nxt   = r_state;
        rom_rd        = 1'b0;
        rom_addr      = '0;
        busy          = 1'b0;
        dilation_done = 1'b0;
        erosion_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dilation_en ^ erosion_en) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                rom_rd   = 1'b1;
                rom_addr = r_rd_addr;
                busy     = 1'b1;
                if (w_abort)                    w_state_nxt = S_IDLE;
                else if (r_rd_addr == LAST_PIX) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                busy = 1'b1;
                if (w_abort)                              w_state_nxt = S_IDLE;
                else if (r_we && (r_waddr == LAST_PIX))   w_state_nxt = S_DONE;
            end
            S_DONE: begin
                dilation_done = !r_mode && dilation_en;
                erosion_done  = r_mode && erosion_en;
                if (!w_mode_en) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: counters, window and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= 1'b0;
            r_rd_addr <= '0;
            r_rd_d    <= 1'b0;
            r_cen     <= 1'b0;
            r_q       <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
            r_win     <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= 1'b0;
        end else begin
            r_rd_d <= rom_rd;
            r_win  <= w_win[WIN-2:0];

            if (w_start) begin
                r_mode    <= erosion_en;
                r_rd_addr <= '0;
                r_cen     <= 1'b0;
                r_q       <= '0;
                r_cx      <= '0;
                r_cy      <= '0;
            end else if (w_active) begin
                if (r_state == S_RUN) begin
                    if (r_rd_addr != LAST_PIX) r_rd_addr <= r_rd_addr + ONE;
                    // Pixel IMG_W+1 arriving next cycle completes the first window
                    if (r_rd_addr == CEN_START) r_cen <= 1'b1;
                end
                if (r_cen) begin
                    if (r_q != LAST_PIX) r_q   <= r_q + ONE;
                    else                 r_cen <= 1'b0;
                    if (r_cx == LAST_X) begin
                        r_cx <= '0;
                        r_cy <= r_cy + ONE;
                    end else begin
                        r_cx <= r_cx + ONE;
                    end
                end
            end else begin
                r_cen <= 1'b0;
            end

            r_we    <= w_wr;
            r_waddr <= w_wr ? r_q : '0;
            r_wdata <= w_wr ? w_out : 1'b0;
        end
    end

    assign ram_we   = r_we;
    assign ram_addr = r_waddr;
    assign ram_data = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_morph_filter_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_morph_filter_engine
// Description : Directed self-checking bench for morph_filter_engine on a
//               16x12 image: dilation/erosion content, borders, line-wrap,
//               write timing, enable conflicts, abort and mid-pass reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morph_filter_engine;

    localparam int W  = 16;
    localparam int H  = 12;
    localparam int AW = 8;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dilation_en = 1'b0;
    logic          erosion_en = 1'b0;
    logic          rom_data = 1'b0;
    logic          rom_rd;
    logic [AW-1:0] rom_addr;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic          ram_data;
    logic          busy;
    logic          dilation_done;
    logic          erosion_done;

    morph_filter_engine #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .dilation_en(dilation_en), .erosion_en(erosion_en),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .busy(busy), .dilation_done(dilation_done), .erosion_done(erosion_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit img [N];
    int ram [N];
    int tests = 0;
    int failed = 0;

    // ROM model: one-cycle read latency
    logic          rd_s = 1'b0;
    logic [AW-1:0] addr_s = '0;
    always @(negedge clk) begin
        rd_s   = rom_rd;
        addr_s = rom_addr;
    end
    always @(posedge clk) rom_data <= rd_s ? img[addr_s] : 1'b0;

    // RAM write monitor
    int wcount = 0, first_w = -1, last_w = -1, order_err = 0, nxt_addr = 0;
    always @(negedge clk) begin
        if (ram_we) begin
            if (first_w < 0) first_w = cyc;
            last_w = cyc;
            if (int'(ram_addr) != nxt_addr) order_err++;
            nxt_addr = int'(ram_addr) + 1;
            ram[ram_addr] = int'(ram_data);
            wcount++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        for (int p = 0; p < N; p++) ram[p] = -1;
        wcount = 0; first_w = -1; last_w = -1; order_err = 0; nxt_addr = 0;
    endtask

    task automatic load_img(input int t);
        for (int p = 0; p < N; p++) img[p] = (t == 3) ? 1'b1 : 1'b0;
        if (t == 1) img[6*W + 8] = 1'b1;
        if (t == 4) begin
            img[0]     = 1'b1;
            img[5*W+15] = 1'b1;
        end
    endtask

    // Hand-derived expected outputs per image/mode
    function automatic int exp_pix(input int t, input int x, input int y);
        case (t)
            1: return (x >= 7 && x <= 9 && y >= 5 && y <= 7) ? 1 : 0;
            2: return 0;
            3: return 1;
            4: return ((x <= 1 && y <= 1) || (x >= 14 && y >= 4 && y <= 6)) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic check_content(input string tag, input int t);
        int bad = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (ram[y*W + x] !== exp_pix(t, x, y)) bad++;
        check({tag, " content mismatches"}, bad, 0);
    endtask

    // Full pass: start, wait for done, check timing/handshake, release enable
    task automatic run_pass(input bit ero, input string tag);
        int c0 = -1;
        int done_c = -1;
        clear_mon();
        @(negedge clk);
        dilation_en = !ero;
        erosion_en  = ero;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rom_rd) begin c0 = cyc; break; end
        end
        check({tag, " pass started"}, (c0 >= 0) ? 1 : 0, 1);
        for (int i = 0; i < N + W + 40; i++) begin
            @(negedge clk);
            if (ero ? erosion_done : dilation_done) begin done_c = cyc; break; end
        end
        #1;
        check({tag, " done seen"}, (done_c >= 0) ? 1 : 0, 1);
        check({tag, " first write cycle"}, first_w - c0, W + 3);
        check({tag, " last write cycle"}, last_w - c0, N + W + 2);
        check({tag, " done latency"}, done_c - last_w, 1);
        check({tag, " write count"}, wcount, N);
        check({tag, " write order errors"}, order_err, 0);
        check({tag, " other done"}, int'(ero ? dilation_done : erosion_done), 0);
        check({tag, " busy in done"}, int'(busy), 0);
        repeat (3) @(negedge clk);
        check({tag, " done held"}, int'(ero ? erosion_done : dilation_done), 1);
        check({tag, " idle ram bus"}, int'({ram_we, ram_addr, ram_data}), 0);
        dilation_en = 1'b0;
        erosion_en  = 1'b0;
        #1;
        check({tag, " done cleared"}, int'({dilation_done, erosion_done}), 0);
        @(negedge clk);
    endtask

    initial begin
        int acts;
        int c0;
        int wsave;

        // Reset with both enables high
        dilation_en = 1'b1;
        erosion_en  = 1'b1;
        load_img(1);
        clear_mon();
        repeat (3) @(negedge clk);
        check("reset outputs", int'({rom_rd, rom_addr, ram_we, ram_addr, ram_data,
                                     busy, dilation_done, erosion_done}), 0);
        rst_n = 1'b1;

        // Both enables high: must stay idle
        acts = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rom_rd || ram_we || busy) acts++;
        end
        check("both enables idle activity", acts, 0);

        // Dropping erosion_en starts a dilation pass
        run_pass(1'b0, "dil single");
        check_content("dil single", 1);
        check("dil single center", ram[6*W+8], 1);
        check("dil single corner (9,7)", ram[7*W+9], 1);
        check("dil single outside (10,6)", ram[6*W+10], 0);

        run_pass(1'b1, "ero single");
        check_content("ero single", 2);

        load_img(3);
        run_pass(1'b1, "ero ones");
        check_content("ero ones", 3);

        load_img(4);
        run_pass(1'b0, "dil edges");
        check_content("dil edges", 4);
        check("no wrap (15,0)", ram[W-1], 0);
        check("no wrap (0,6)", ram[6*W], 0);

        // Abort mid-RUN
        load_img(1);
        clear_mon();
        dilation_en = 1'b1;
        c0 = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rom_rd) begin c0 = cyc; break; end
        end
        check("abort pass started", (c0 >= 0) ? 1 : 0, 1);
        while (cyc < c0 + 100) @(negedge clk);
        dilation_en = 1'b0;
        @(negedge clk);
        check("abort outputs", int'({rom_rd, ram_we, busy, dilation_done, erosion_done}), 0);
        acts = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rom_rd || ram_we || busy || dilation_done) acts++;
        end
        check("abort stays idle", acts, 0);

        // Reset mid-RUN
        dilation_en = 1'b1;
        repeat (60) @(negedge clk);
        check("busy before reset", int'(busy), 1);
        rst_n = 1'b0;
        dilation_en = 1'b0;
        #1;
        check("async reset outputs", int'({rom_rd, rom_addr, ram_we, ram_addr, ram_data,
                                           busy, dilation_done, erosion_done}), 0);
        wsave = wcount;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no writes after reset", wcount - wsave, 0);

        run_pass(1'b0, "dil after reset");
        check_content("dil after reset", 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/morph_filter_engine.md
Name: morph_filter_engine

Overview:
Responder to the top-level control FSM's filter enables. On dilation_en or erosion_en, it streams a binary image out of the source ROM in raster order and applies a 3x3 binary dilation or erosion. It writes the result image to the frame RAM and reports completion on dilation_done or erosion_done, the flags the control FSM waits on. It sits between the ROM reader and the RAM writer in the processing pipeline.

Parameters:
IMG_W, 160, image width in pixels (must be >= 3)
IMG_H, 120, image height in lines (must be >= 3)
ADDR_W, 15, ROM/RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  system clock, VGA_CTRL_CLK domain
rst_n  in  1  asynchronous active-low reset
dilation_en  in  1  level request for a dilation pass
erosion_en  in  1  level request for an erosion pass
rom_rd  out  1  ROM read strobe
rom_addr  out  ADDR_W  ROM pixel address
rom_data  in  1  ROM pixel, valid exactly 1 cycle after the rom_rd cycle
ram_we  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM pixel address
ram_data  out  1  filtered pixel
busy  out  1  high in RUN and FLUSH
dilation_done  out  1  dilation pass complete (level)
erosion_done  out  1  erosion pass complete (level)

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low. Every output resets to 0, state resets to IDLE and counters reset to 0.
- Let N = IMG_W*IMG_H. Pixel index p = y*IMG_W + x.
- States are IDLE, RUN, FLUSH and DONE, one-hot encoded.
- IDLE:
  - Start condition is exactly one of the two enables high. On start, latch mode (DIL or ERO) and go to RUN; the first RUN cycle is C0.
  - Both enables high, or neither high: stay in IDLE.
- RUN:
  - rom_rd=1 and rom_addr=p at cycle C0+p, for p = 0..N-1, with no gaps.
  - After p=N-1, go to FLUSH.
- FLUSH:
  - rom_rd=0.
  - Feeds IMG_W+1 padding pixels into the window to drain the pipeline.
  - Go to DONE after the last write.
- Window:
  - A shift register of 2*IMG_W+3 bits shifts in rom_data, or padding during FLUSH.
  - The center tap is pixel q; taps cover q +/- 1 and q +/- IMG_W (+/- 1).
- Borders:
  - Neighbors outside the image use padding: 0 in DIL mode, 1 in ERO mode.
  - Masking uses center x/y counters. There is no wrap-around between the right edge of one line and the left edge of the next.
- Function:
  - DIL: out = OR of the 9 window bits.
  - ERO: out = AND of the 9 window bits.
  - The result is registered.
- Write timing:
  - ram_we=1, ram_addr=q, ram_data=out(q) at cycle C0+IMG_W+3+q, for q = 0..N-1.
  - Exactly N contiguous write cycles, in ascending address order.
  - Outside these cycles, ram_we=0 and ram_addr/ram_data hold 0.
- DONE:
  - busy=0.
  - Assert the done flag matching the latched mode and hold it while that enable stays high.
  - When that enable drops, clear the flag and go to IDLE.
- Abort:
  - If the latched-mode enable drops in RUN or FLUSH, return to IDLE next cycle.
  - rom_rd, ram_we and busy go 0 that cycle; no done flag is raised.
  - RAM contents are left partial.
- Enable changes during a pass:
  - The opposite enable rising in RUN, FLUSH or DONE is ignored.
  - A new pass requires a return to IDLE.
- Reset mid-operation: async clear as above. There are no spurious ram_we pulses after reset.
- Counters: ADDR_W wide. The read counter saturates at N-1 and never wraps.

Test Plan:
1. All-zero image except pixel (80,60)=1, dilation_en=1 -> ram_data=1 at exactly x 79..81, y 59..61 (9 writes), 0 elsewhere; N writes; dilation_done=1 held.
2. Same image, erosion_en=1 -> all N writes 0; erosion_done=1, dilation_done=0.
3. All-ones image, erosion_en=1 -> all N outputs 1 (padding 1, border not eroded). Single pixel at (0,0), dilation -> ones at (0,0),(1,0),(0,1),(1,1) only, and (159,0) stays 0 (no line wrap).
4. Timing, IMG_W=160: first ram_we at C0+163 with ram_addr=0; last ram_we at C0+N+162 with ram_addr=19199; done asserts the following cycle.
5. Both enables high from reset -> stays IDLE, rom_rd=0 and ram_we=0 for 1000 cycles. Then drop erosion_en -> dilation pass starts.
6. Drop dilation_en at C0+500 -> next cycle rom_rd=0, ram_we=0, busy=0, no done. Then pull rst_n low mid-RUN -> all outputs 0 immediately; after release, a new pass runs to completion correctly.
